// File: rtl/argmax_pkg.sv
// Shared types for the argmax frame scheduler: engine FSM states and bank index.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD
    } eng_state_t;

    typedef logic bank_idx_t;

    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/argmax_sched_score_bank.sv
// One ping-pong score bank: slot storage, written-mask, full/err flags, zero-masked packed read.
// Single-cycle write; read is combinational from registers. The written-mask clears when the bank is released.
module score_bank #(
    parameter int NUMINPUT   = 10,
    parameter int INPUTWIDTH = 16,
    parameter int IW         = $clog2(NUMINPUT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_vld,
    input  logic [IW-1:0]                  i_wr_idx,
    input  logic [INPUTWIDTH-1:0]          i_wr_dat,
    input  logic                           i_commit,
    input  logic                           i_err,
    input  logic                           i_release,
    output logic                           o_full,
    output logic                           o_err,
    output logic [NUMINPUT*INPUTWIDTH-1:0] o_rd_dat
);

    logic [INPUTWIDTH-1:0] r_score [NUMINPUT];
    logic [NUMINPUT-1:0]   r_mask;
    logic                  r_full;
    logic                  r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUMINPUT; k++) begin
                r_score[k] <= '0;
            end
            r_mask <= '0;
            r_full <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            // Releasing the bank lets the next frame start with every slot reading as zero.
            if (i_release) begin
                r_mask <= '0;
            end else if (i_wr_vld) begin
                r_mask[i_wr_idx] <= 1'b1;
            end
            if (i_wr_vld) begin
                r_score[i_wr_idx] <= i_wr_dat;
            end
            if (i_commit) begin
                r_full <= 1'b1;
                r_err  <= i_err;
            end else if (i_release) begin
                r_full <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rd_dat = '0;
        for (int k = 0; k < NUMINPUT; k++) begin
            o_rd_dat[k*INPUTWIDTH +: INPUTWIDTH] = r_mask[k] ? r_score[k] : '0;
        end
    end

    assign o_full = r_full;
    assign o_err  = r_err;

endmodule

// File: rtl/argmax_sched.sv
// Collects serial score frames into two banks, launches the argmax engine once per frame, returns the class index.
// m_valid rises NUMINPUT+3 edges after the last beat when idle; s_ready drops only while the filling bank is full.
module argmax_sched
    import argmax_pkg::*;
#(
    parameter int NUMINPUT     = 10,
    parameter int INPUTWIDTH   = 16,
    parameter int OPDATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [INPUTWIDTH-1:0]          s_data,
    input  logic                           s_last,
    output logic [NUMINPUT*INPUTWIDTH-1:0] eng_ip_data,
    output logic                           eng_ip_valid,
    input  logic [OPDATA_WIDTH-1:0]        eng_op_data,
    input  logic                           eng_op_data_valid,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [OPDATA_WIDTH-1:0]        m_class,
    output logic                           m_err,
    output logic                           busy
);

    localparam int CW = $clog2(NUMINPUT + 1);
    localparam int IW = $clog2(NUMINPUT);

    bank_idx_t                r_wr_ptr;
    bank_idx_t                r_rd_ptr;
    logic [CW-1:0]            r_beat_cnt;
    logic                     r_ovf;
    eng_state_t               r_state;
    eng_state_t               w_state_nxt;
    logic                     r_eng_ip_valid;
    logic                     r_m_valid;
    logic [OPDATA_WIDTH-1:0]  r_m_class;
    logic                     r_m_err;
    logic                     r_busy;

    logic                     w_beat_acc;
    logic                     w_slot_ok;
    logic                     w_commit;
    logic                     w_frame_err;
    logic                     w_release;
    logic                     w_capture;
    logic [NUM_BANKS-1:0]     w_full;
    logic [NUM_BANKS-1:0]     w_err;
    logic [NUM_BANKS-1:0]     w_wr_vld;
    logic [NUM_BANKS-1:0]     w_commit_b;
    logic [NUM_BANKS-1:0]     w_rel_b;
    logic [NUM_BANKS-1:0]     w_full_nxt;
    logic [NUMINPUT*INPUTWIDTH-1:0] w_rd_dat [NUM_BANKS];

    assign s_ready     = ~w_full[r_wr_ptr];
    assign w_beat_acc  = s_valid & s_ready;
    assign w_slot_ok   = r_beat_cnt < CW'(NUMINPUT);
    assign w_commit    = w_beat_acc & s_last;
    // The frame is clean only if this last beat is exactly beat NUMINPUT and nothing overflowed earlier.
    assign w_frame_err = r_ovf | (r_beat_cnt != CW'(NUMINPUT - 1));
    assign w_release   = (r_state == LAUNCH);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign w_wr_vld[b]   = w_beat_acc & w_slot_ok & (r_wr_ptr == bank_idx_t'(b));
        assign w_commit_b[b] = w_commit & (r_wr_ptr == bank_idx_t'(b));
        assign w_rel_b[b]    = w_release & (r_rd_ptr == bank_idx_t'(b));

        score_bank #(
            .NUMINPUT   (NUMINPUT),
            .INPUTWIDTH (INPUTWIDTH),
            .IW         (IW)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_vld  (w_wr_vld[b]),
            .i_wr_idx  (r_beat_cnt[IW-1:0]),
            .i_wr_dat  (s_data),
            .i_commit  (w_commit_b[b]),
            .i_err     (w_frame_err),
            .i_release (w_rel_b[b]),
            .o_full    (w_full[b]),
            .o_err     (w_err[b]),
            .o_rd_dat  (w_rd_dat[b])
        );
    end

    assign w_full_nxt  = (w_full & ~w_rel_b) | w_commit_b;
    assign eng_ip_data = w_rd_dat[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_commit) begin
            r_wr_ptr   <= ~r_wr_ptr;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_beat_acc) begin
            if (w_slot_ok) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE:   if (w_full[r_rd_ptr]) w_state_nxt = LAUNCH;
            LAUNCH: w_state_nxt = WAIT;
            WAIT: begin
                if (eng_op_data_valid) begin
                    w_state_nxt = HOLD;
                    w_capture   = 1'b1;
                end
            end
            HOLD:   if (m_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr       <= 1'b0;
            r_eng_ip_valid <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_class      <= '0;
            r_m_err        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_eng_ip_valid <= (w_state_nxt == LAUNCH);
            r_busy         <= (|w_full_nxt) | (w_state_nxt != IDLE);
            if (w_release) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_m_err  <= w_err[r_rd_ptr];
            end
            if (w_capture) begin
                r_m_class <= eng_op_data;
                r_m_valid <= 1'b1;
            end else if ((r_state == HOLD) && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign eng_ip_valid = r_eng_ip_valid;
    assign m_valid      = r_m_valid;
    assign m_class      = r_m_class;
    assign m_err        = r_m_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_argmax_sched.sv
// Bench for argmax_sched: behavioural argmax engine plus an in-order result scoreboard.
module tb_argmax_sched;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int OW = 32;

    typedef struct packed {
        logic [OW-1:0] cls;
        logic          err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             s_last;
    logic [N*W-1:0]   eng_ip_data;
    logic             eng_ip_valid;
    logic [OW-1:0]    eng_op_data;
    logic             eng_op_data_valid;
    logic             m_valid;
    logic             m_ready;
    logic [OW-1:0]    m_class;
    logic             m_err;
    logic             busy;

    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               launches = 0;
    int               eng_cnt  = 0;
    int               rise_cyc = 0;
    int               last_cyc = 0;
    logic             mv_prev  = 1'b0;
    logic             eng_fire = 1'b0;
    logic             eng_force = 1'b0;
    logic [OW-1:0]    eng_res  = '0;
    logic [N*W-1:0]   last_ip  = '0;
    logic [W-1:0]     fv [16];
    exp_t             sb [$];

    argmax_sched #(
        .NUMINPUT     (N),
        .INPUTWIDTH   (W),
        .OPDATA_WIDTH (OW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_last            (s_last),
        .eng_ip_data       (eng_ip_data),
        .eng_ip_valid      (eng_ip_valid),
        .eng_op_data       (eng_op_data),
        .eng_op_data_valid (eng_op_data_valid),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_class           (m_class),
        .m_err             (m_err),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] f_argmax(input logic [N*W-1:0] d);
        int best = 0;
        for (int k = 1; k < N; k++) begin
            if (d[k*W +: W] > d[best*W +: W]) best = k;
        end
        return OW'(best);
    endfunction

    // Engine: samples on the edge after a negedge that sees eng_ip_valid, answers N edges later.
    assign eng_op_data_valid = eng_fire | eng_force;
    assign eng_op_data       = eng_res;

    always @(negedge clk) begin
        if (eng_ip_valid) begin
            check("eng_idle_at_start", eng_cnt == 0, 1);
            last_ip  = eng_ip_data;
            eng_res  = f_argmax(eng_ip_data);
            eng_cnt  = N + 1;
            launches = launches + 1;
            eng_fire = 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt  = eng_cnt - 1;
            eng_fire = (eng_cnt == 0);
        end else begin
            eng_fire = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_valid && !mv_prev) rise_cyc = cyc;
        mv_prev = m_valid;
        if (rst_n && m_valid && m_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("m_class", m_class, e.cls);
                check("m_err", m_err, e.err);
            end
        end
    end

    task automatic send_frame(input int n);
        exp_t           e;
        logic [N*W-1:0] img;
        int             t;
        img = '0;
        for (int k = 0; k < N; k++) begin
            if (k < n) img[k*W +: W] = fv[k];
        end
        e.cls = f_argmax(img);
        e.err = (n != N);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = fv[i];
            s_last  = (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 300) begin
                t++;
                @(negedge clk);
            end
            if (t >= 300) check("s_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || m_valid || busy) && t < 400) begin
            t++;
            @(negedge clk);
        end
        check(tag, t < 400, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int   l0;
        int   t;
        logic saw_mv;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        for (int k = 0; k < 16; k++) fv[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_eng_ip_valid", eng_ip_valid, 0);
        check("rst_eng_ip_data", eng_ip_data == '0, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_class", m_class, 0);
        check("rst_m_err", m_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal frame, latency and single launch.
        fv = '{5, 9, 3, 1, 0, 2, 4, 900, 8, 7, 0, 0, 0, 0, 0, 0};
        l0 = launches;
        send_frame(10);
        @(negedge clk);
        check("busy_after_commit", busy, 1);
        wait_drain("t1_drain");
        check("t1_latency", rise_cyc - last_cyc, N + 3);
        check("t1_launches", launches - l0, 1);

        // All-equal tie goes to index 0.
        for (int k = 0; k < 10; k++) fv[k] = 16'd42;
        send_frame(10);
        wait_drain("t2_drain");

        // Short frame: unwritten slots read as zero.
        fv = '{3, 50, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(4);
        wait_drain("t3_drain");
        check("t3_ip_hi_zero", last_ip[N*W-1:4*W] == '0, 1);
        check("t3_ip_lo", last_ip[4*W-1:0], 64'h0001_0002_0032_0003);

        // Long frame: beats past N are dropped.
        for (int k = 0; k < 9; k++) fv[k] = W'(k * 3);
        fv[9]  = 16'd500;
        fv[10] = 16'd999;
        fv[11] = 16'd1000;
        send_frame(12);
        wait_drain("t4_drain");

        // Three frames with downstream stalled, then released.
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 10; k++) fv[k] = (k == 2 + 3 * f) ? 16'd300 : W'(k);
            send_frame(10);
        end
        @(negedge clk);
        check("t5_s_ready_low", s_ready, 0);
        check("t5_m_valid_hold", m_valid, 1);
        check("t5_sb_depth", sb.size(), 3);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain("t5_drain");
        check("t5_s_ready_back", s_ready, 1);

        // Reset while the engine is running; the late result must be ignored.
        for (int k = 0; k < 10; k++) fv[k] = W'(k + 1);
        l0 = launches;
        send_frame(10);
        t = 0;
        while (launches == l0 && t < 50) begin
            t++;
            @(posedge clk);
        end
        check("t6_launch_seen", launches - l0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_mv = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(negedge clk);
            if (m_valid) saw_mv = 1'b1;
            if (i == 2) eng_force = 1'b1;
            if (i == 3) eng_force = 1'b0;
        end
        check("t6_no_m_valid", saw_mv, 0);
        check("t6_s_ready", s_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_m_class", m_class, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
